// File: rtl/ife_deser_pkg.sv
// ife_deser_pkg: shared types, defaults and the counter-width helper for the deserializer
package ife_deser_pkg;
  typedef enum logic {HUNT, LOCK} state_e;
  localparam int DEF_WIDTH = 8;
  localparam logic [7:0] DEF_SYNC_WORD = 8'hB8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/ife_deser_rx_if.sv
// ife_deser_rx_if: serial input / framed output bundle for ife_deser_rx
//   D, SP, HUNT_REQ, SLIP (IFE_DESER_BITSLIP_EN only) : driven by master
//   Q, QV, LOCKED                                      : driven by slave (the deserializer)
interface ife_deser_rx_if #(parameter int WIDTH = ife_deser_pkg::DEF_WIDTH);
  logic D;
  logic SP;
  logic HUNT_REQ;
`ifdef IFE_DESER_BITSLIP_EN
  logic SLIP;
`endif
  logic [WIDTH-1:0] Q;
  logic QV;
  logic LOCKED;
  modport master (
    output D, SP, HUNT_REQ,
`ifdef IFE_DESER_BITSLIP_EN
    output SLIP,
`endif
    input Q, QV, LOCKED
  );
  modport slave (
    input D, SP, HUNT_REQ,
`ifdef IFE_DESER_BITSLIP_EN
    input SLIP,
`endif
    output Q, QV, LOCKED
  );
endinterface

// File: rtl/ife_deser_shreg.sv
// ife_deser_shreg: SP-enabled serial shift register with synchronous clear, exposes next value
//   clk, rst : clock, synchronous active-high clear
//   en_i     : shift enable
//   d_i      : serial bit entering at the LSB
//   nxt_o    : WIDTH-bit window including the incoming bit
module ife_deser_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] nxt_o
);
  // The oldest bit falls out as nxt is formed, so only WIDTH-1 bits need storage.
  logic [WIDTH-2:0] shreg_q;
  assign nxt_o = {shreg_q, d_i};
  always_ff @(posedge clk)
    if (rst) shreg_q <= '0;
    else if (en_i) shreg_q <= nxt_o[WIDTH-2:0];
endmodule

// File: rtl/ife_deser_rx.sv
// ife_deser_rx: serial receiver that hunts for SYNC_WORD then frames WIDTH-bit words
//   ECLK : edge clock, rising edge
//   CD   : synchronous active-high reset
//   bus  : ife_deser_rx_if slave (D, SP, HUNT_REQ, [SLIP] in; Q, QV, LOCKED out)
//   IFE_DESER_BITSLIP_EN : enables SLIP (hold the word counter for one sample in LOCK)
module ife_deser_rx
  import ife_deser_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DEF_SYNC_WORD)
) (
  input  logic          ECLK,
  input  logic          CD,
  ife_deser_rx_if.slave bus
);
  localparam int CW = clog2(WIDTH);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d, nxt;
  logic             qv_q, qv_d, slip, wrap;
`ifdef IFE_DESER_BITSLIP_EN
  assign slip = bus.SLIP;
`else
  assign slip = 1'b0;
`endif
  ife_deser_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk  (ECLK),
    .rst  (CD),
    .en_i (bus.SP),
    .d_i  (bus.D),
    .nxt_o(nxt)
  );
  assign wrap = cnt_q == CW'(WIDTH - 1);
  // HUNT_REQ beats both a sync match and a completing word; SLIP stalls the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    qv_d    = 1'b0;
    if (bus.SP) begin
      if (bus.HUNT_REQ) begin
        state_d = HUNT;
        cnt_d   = '0;
      end else if (state_q == HUNT) begin
        state_d = nxt == SYNC_WORD ? LOCK : HUNT;
        cnt_d   = '0;
      end else if (!slip) begin
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        q_d   = wrap ? nxt : q_q;
        qv_d  = wrap;
      end
    end
  end
  always_ff @(posedge ECLK)
    if (CD) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
    end
  assign bus.Q      = q_q;
  assign bus.QV     = qv_q;
  assign bus.LOCKED = state_q == LOCK;
endmodule

// File: tb/tb_ife_deser_rx.sv
// tb_ife_deser_rx: directed and random checks of ife_deser_rx against a bit-history model
module tb_ife_deser_rx;
  localparam int W = 8;
  localparam logic [7:0] SYNC = 8'hB8;
`ifdef IFE_DESER_BITSLIP_EN
  localparam bit SLIP_EN = 1'b1;
`else
  localparam bit SLIP_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic cd  = 1'b1;
  int checks = 0;
  int fails  = 0;
  bit hist[$];
  int since;
  bit m_lock, m_qv;
  logic [7:0] m_q;
  logic [7:0] words[$];
  ife_deser_rx_if #(.WIDTH(W)) bus ();
  ife_deser_rx #(.WIDTH(W), .SYNC_WORD(SYNC)) dut (
    .ECLK(clk),
    .CD  (cd),
    .bus (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] window();
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < W; i++) w = {w[6:0], hist[hist.size() - W + i]};
    return w;
  endfunction
  // Reference: the last W sampled bits form the candidate word; after lock, every W
  // counted samples (slipped samples do not count) deliver that window.
  task automatic model(input bit r, input bit d, input bit sp, input bit hr, input bit sl);
    logic [7:0] win;
    if (r) begin
      hist = {};
      repeat (W) hist.push_back(1'b0);
      m_lock = 0; since = 0; m_q = '0; m_qv = 0;
    end else if (!sp) begin
      m_qv = 0;
    end else begin
      hist.push_back(d);
      void'(hist.pop_front());
      win  = window();
      m_qv = 0;
      if (hr) m_lock = 0;
      else if (!m_lock) begin
        if (win == SYNC) begin m_lock = 1; since = 0; end
      end else if (!(sl && SLIP_EN)) begin
        since++;
        if (since == W) begin since = 0; m_q = win; m_qv = 1; end
      end
    end
  endtask
  task automatic step(input bit r, input bit d, input bit sp, input bit hr, input bit sl);
    cd = r;
    bus.D = d;
    bus.SP = sp;
    bus.HUNT_REQ = hr;
`ifdef IFE_DESER_BITSLIP_EN
    bus.SLIP = sl;
`endif
    @(posedge clk);
    model(r, d, sp, hr, sl);
    #1;
    chk("q", bus.Q, m_q);
    chk("qv", bus.QV, m_qv);
    chk("locked", bus.LOCKED, m_lock);
    if (bus.QV === 1'b1) words.push_back(bus.Q);
  endtask
  task automatic send(input logic [7:0] b, input bit hr_last);
    for (int i = 7; i >= 0; i--) step(0, b[i], 1, hr_last && i == 0, 0);
  endtask
  task automatic restart();
    step(1, 0, 1, 0, 0);
    words = {};
  endtask
  task automatic chk_words(input string tag, input int n, input logic [7:0] w0, input logic [7:0] w1);
    chk({tag, "_n"}, words.size(), n);
    if (n > 0) chk({tag, "_w0"}, words.size() > 0 ? {24'h0, words[0]} : 32'hDEAD, {24'h0, w0});
    if (n > 1) chk({tag, "_w1"}, words.size() > 1 ? {24'h0, words[1]} : 32'hDEAD, {24'h0, w1});
  endtask
  initial begin
    logic [7:0] b;
    bit sy;
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("rst_q", bus.Q, 0);
    chk("rst_qv", bus.QV, 0);
    chk("rst_locked", bus.LOCKED, 0);
    restart();
    send(SYNC, 0);
    chk("t2_lock", bus.LOCKED, 1);
    send(8'h5A, 0);
    send(8'h3C, 0);
    chk_words("t2", 2, 8'h5A, 8'h3C);
    restart();
    send(SYNC, 0);
    for (int i = 7; i >= 4; i--) step(0, b8(8'h5A, i), 1, 0, 0);
    repeat (3) step(0, 1'($urandom), 0, 0, 0);
    for (int i = 3; i >= 0; i--) step(0, b8(8'h5A, i), 1, 0, 0);
    send(8'h3C, 0);
    chk_words("t3", 2, 8'h5A, 8'h3C);
    restart();
    send(SYNC, 0);
    send(8'h5A, 1);
    chk("t4_unlock", bus.LOCKED, 0);
    chk_words("t4a", 0, 0, 0);
    send(SYNC, 0);
    chk("t4_relock", bus.LOCKED, 1);
    send(8'h3C, 0);
    chk_words("t4b", 1, 8'h3C, 0);
    restart();
    send(SYNC, 0);
    send(SYNC, 0);
    chk("t5_lock", bus.LOCKED, 1);
    chk_words("t5", 1, SYNC, 0);
`ifdef IFE_DESER_BITSLIP_EN
    restart();
    send(SYNC, 0);
    step(0, 1, 1, 0, 1);
    send(8'h5A, 0);
    chk_words("t6", 1, 8'h5A, 0);
`endif
    restart();
    repeat (300) begin
      sy = $urandom_range(0, 3) == 0;
      b = sy ? SYNC : 8'($urandom);
      for (int i = 7; i >= 0; i--)
        step($urandom_range(0, 199) == 0, b[i], $urandom_range(0, 4) != 0,
             $urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
  function automatic bit b8(input logic [7:0] v, input int i);
    return v[i];
  endfunction
endmodule
